ram_2p_lane_clr: RTL and testbench
==================================

Name: ram_2p_lane_clr

Overview:
Parametrised simple dual-port block RAM for the neighbour-info stores (intra pred modes, ref_idx, mv candidates). It has one write port and one read port, per-lane write enables, same-cycle write-to-read forwarding, an optional output pipeline register, and a hardware clear sequencer. The clear sequencer sweeps every address to a fixed value after reset or on request, for example at slice or picture start, so no firmware loop is needed.

Parameters:
addr_bits, 8, address width; depth = 1 << addr_bits.
data_bits, 16, word width; must be a multiple of lane_bits.
lane_bits, 8, width of one write-enable lane; lanes = data_bits / lane_bits.
out_reg, 0, 0 gives read latency 1; 1 adds an output register for read latency 2.
clear_value, 0, value written to every word by the clear sweep (data_bits wide).
clear_on_reset, 1, 1 starts a clear sweep automatically when rst deasserts.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous active-high reset.
clr  input  1  one-cycle pulse that starts or restarts a clear sweep.
busy  output  1  high while the clear sweep runs.
wr_en  input  1  write request.
wr_addr  input  addr_bits  write address.
wr_lane_en  input  lanes  per-lane write enable; lane k covers bits [k*lane_bits +: lane_bits].
wr_data  input  data_bits  write data.
rd_en  input  1  read request.
rd_addr  input  addr_bits  read address.
rd_data  output  data_bits  read data; holds its value between reads.
rd_valid  output  1  high for one cycle when rd_data carries new read data.

Behaviour:
- Reset values: rd_data = 0, rd_valid = 0, busy = clear_on_reset, sweep counter = 0. If out_reg = 1, the pipeline valid bit is also 0. Memory contents are not touched by rst itself.
- FSM states: IDLE and CLEAR.
  - While rst is high: state = CLEAR if clear_on_reset = 1, else IDLE.
  - IDLE, clr = 1: go to CLEAR; counter = 0; busy goes high the next cycle.
  - CLEAR, every cycle: write clear_value to all lanes of ram[counter], then counter += 1.
  - CLEAR, counter = depth-1: write the last word, then go to IDLE; busy goes low the next cycle.
  - A sweep is exactly depth cycles of busy.
  - clr during CLEAR: counter restarts at 0 and the sweep lasts a further depth cycles.
  - rst during CLEAR: aborts the sweep immediately; reset rules above then apply.
- During busy, wr_en and rd_en are ignored: no user write, rd_valid = 0, rd_data holds.
- Write (IDLE, wr_en = 1): for each lane k with wr_lane_en[k] = 1, that lane of ram[wr_addr] takes wr_data. Other lanes keep their value. wr_lane_en = 0 means no change.
- Read (IDLE, rd_en = 1) with out_reg = 0: on the next edge rd_data = ram[rd_addr] and rd_valid = 1 for one cycle.
- Read with out_reg = 1: rd_data and rd_valid appear one cycle later. Back-to-back reads are allowed every cycle with full throughput.
- Same-cycle forwarding: if wr_en and rd_en are both high and wr_addr = rd_addr, the returned word has new wr_data on enabled lanes and old contents on the rest (write-first per lane).
- A write in a cycle after the read cycle does not alter that read's result, even with out_reg = 1.
- clr together with rd_en in the same IDLE cycle: the read is serviced with pre-clear contents. A simultaneous wr_en is dropped.
- Address wrap: the sweep counter is addr_bits + 1 wide so termination is exact. No out-of-range addresses exist.
- Storage is inferred as block RAM (ram_style block). The forwarding mux and clear-address mux sit outside the array.

Test Plan:
- Reset with clear_on_reset = 1, addr_bits = 4: busy high for exactly 16 cycles after rst falls. Reading all 16 addresses afterwards returns 0x0000 each, with rd_valid pulses one cycle after each rd_en.
- Write 0xABCD to addr 5, then write wr_lane_en = 2'b01 with data 0x1234 to addr 5. A read of addr 5 returns 0xAB34.
- Same cycle: write 0x5566 (lanes 2'b10) to addr 3 while reading addr 3, which holds 0x1122. rd_data = 0x5522 one cycle later (out_reg = 0), or two cycles later (out_reg = 1).
- out_reg = 1: reads of addrs 0, 1, 2 on consecutive cycles produce rd_valid high on cycles +2, +3 and +4 with matching data. A write to addr 1 in the cycle after its read does not change the returned value.
- clr pulse in IDLE, then a second clr 6 cycles into the sweep (depth 16): busy stays high for 6 + 16 = 22 cycles. wr_en and rd_en during busy produce no write and no rd_valid. Afterwards every address reads clear_value = 0x00FF.
- rst asserted mid-sweep with clear_on_reset = 0: busy = 0 the cycle after rst. Addresses beyond the abort point keep their old data on readback.

Source files
------------

// File: rtl/ram_2p_lane_clr.sv
// ram_2p_lane_clr: simple dual-port RAM with per-lane write enables,
// write-first forwarding on address collision, optional output register,
// and a clear sequencer that sweeps every word to clear_value.
module ram_2p_lane_clr #(
    parameter int                   addr_bits      = 8,
    parameter int                   data_bits      = 16,
    parameter int                   lane_bits      = 8,
    parameter int                   out_reg        = 0,
    parameter logic [data_bits-1:0] clear_value    = '0,
    parameter int                   clear_on_reset = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr_i,
    output logic                           busy_o,
    input  logic                           wr_en_i,
    input  logic [addr_bits-1:0]           wr_addr_i,
    input  logic [data_bits/lane_bits-1:0] wr_lane_en_i,
    input  logic [data_bits-1:0]           wr_data_i,
    input  logic                           rd_en_i,
    input  logic [addr_bits-1:0]           rd_addr_i,
    output logic [data_bits-1:0]           rd_data_o,
    output logic                           rd_valid_o
);

    localparam int LANES = data_bits / lane_bits;
    localparam int DEPTH = 1 << addr_bits;
    localparam int CNT_W = addr_bits + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    state_e             state_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [LANES-1:0]     mem_we_d;
    logic [addr_bits-1:0] mem_waddr_d;
    logic [data_bits-1:0] mem_wdata_d;
    logic                 rd_go_d;
    logic                 fwd_hit_d;

    (* ram_style = "block" *) logic [data_bits-1:0] mem_q [DEPTH];
    logic [data_bits-1:0] ram_rd_q;

    logic [LANES-1:0]     fwd_mask_q;
    logic [data_bits-1:0] fwd_data_q;
    logic                 rd1_valid_q;
    logic [data_bits-1:0] rd1_data_d;

    // Clear sequencer: IDLE/CLEAR state, sweep counter and busy flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= (clear_on_reset != 0) ? ST_CLEAR : ST_IDLE;
            busy_q  <= (clear_on_reset != 0);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clr_i) begin
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;

    // Write-port mux (sweep vs user) and read/forward qualification.
    always_comb begin
        mem_we_d    = '0;
        mem_waddr_d = wr_addr_i;
        mem_wdata_d = wr_data_i;
        if (rst_i) begin
            mem_we_d = '0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_d    = '1;
            mem_waddr_d = cnt_q[addr_bits-1:0];
            mem_wdata_d = clear_value;
        end else if (wr_en_i && !clr_i) begin
            mem_we_d = wr_lane_en_i;
        end else begin
            mem_we_d = '0;
        end
        rd_go_d   = !rst_i && (state_q == ST_IDLE) && rd_en_i;
        fwd_hit_d = wr_en_i && !clr_i && (wr_addr_i == rd_addr_i);
    end

    // Storage array: lane-masked write and registered read of old contents.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < LANES; k++) begin
            if (mem_we_d[k]) begin
                mem_q[mem_waddr_d][k*lane_bits +: lane_bits] <= mem_wdata_d[k*lane_bits +: lane_bits];
            end
        end
        if (rd_go_d) begin
            ram_rd_q <= mem_q[rd_addr_i];
        end
    end

    // Forwarding capture: lanes written in the read cycle override the array word.
    // Reset selects all lanes from a zero word so the output starts at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fwd_mask_q  <= '1;
            fwd_data_q  <= '0;
            rd1_valid_q <= 1'b0;
        end else if (rd_go_d) begin
            fwd_mask_q  <= fwd_hit_d ? wr_lane_en_i : '0;
            fwd_data_q  <= wr_data_i;
            rd1_valid_q <= 1'b1;
        end else begin
            rd1_valid_q <= 1'b0;
        end
    end

    // Per-lane merge of forwarded write data and array read data.
    always_comb begin
        rd1_data_d = '0;
        for (int k = 0; k < LANES; k++) begin
            if (fwd_mask_q[k]) begin
                rd1_data_d[k*lane_bits +: lane_bits] = fwd_data_q[k*lane_bits +: lane_bits];
            end else begin
                rd1_data_d[k*lane_bits +: lane_bits] = ram_rd_q[k*lane_bits +: lane_bits];
            end
        end
    end

    if (out_reg != 0) begin : g_out_reg
        logic [data_bits-1:0] rd2_data_q;
        logic                 rd2_valid_q;

        // Output pipeline stage: adds one cycle of latency, holds data between reads.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd2_data_q  <= '0;
                rd2_valid_q <= 1'b0;
            end else begin
                rd2_valid_q <= rd1_valid_q;
                if (rd1_valid_q) begin
                    rd2_data_q <= rd1_data_d;
                end
            end
        end

        assign rd_data_o  = rd2_data_q;
        assign rd_valid_o = rd2_valid_q;
    end else begin : g_no_out_reg
        assign rd_data_o  = rd1_data_d;
        assign rd_valid_o = rd1_valid_q;
    end

endmodule

// File: tb/tb_ram_2p_lane_clr.sv
// Scoreboard bench for ram_2p_lane_clr: two instances (latency 1 with
// clear-on-reset, latency 2 with manual clear to 0x00FF).
module tb_ram_2p_lane_clr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    logic        a_rst, a_clr, a_busy, a_wr_en, a_rd_en, a_rd_valid;
    logic [3:0]  a_wr_addr, a_rd_addr;
    logic [1:0]  a_wr_lane_en;
    logic [15:0] a_wr_data, a_rd_data;

    logic        b_rst, b_clr, b_busy, b_wr_en, b_rd_en, b_rd_valid;
    logic [3:0]  b_wr_addr, b_rd_addr;
    logic [1:0]  b_wr_lane_en;
    logic [15:0] b_wr_data, b_rd_data;

    ram_2p_lane_clr #(
        .addr_bits(4), .data_bits(16), .lane_bits(8), .out_reg(0),
        .clear_value(16'h0000), .clear_on_reset(1)
    ) u_a (
        .clk_i(clk), .rst_i(a_rst), .clr_i(a_clr), .busy_o(a_busy),
        .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_lane_en_i(a_wr_lane_en),
        .wr_data_i(a_wr_data), .rd_en_i(a_rd_en), .rd_addr_i(a_rd_addr),
        .rd_data_o(a_rd_data), .rd_valid_o(a_rd_valid)
    );

    ram_2p_lane_clr #(
        .addr_bits(4), .data_bits(16), .lane_bits(8), .out_reg(1),
        .clear_value(16'h00FF), .clear_on_reset(0)
    ) u_b (
        .clk_i(clk), .rst_i(b_rst), .clr_i(b_clr), .busy_o(b_busy),
        .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_lane_en_i(b_wr_lane_en),
        .wr_data_i(b_wr_data), .rd_en_i(b_rd_en), .rd_addr_i(b_rd_addr),
        .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_set_wr(input logic [3:0] ad, input logic [1:0] ln, input logic [15:0] d);
        a_wr_en = 1'b1; a_wr_addr = ad; a_wr_lane_en = ln; a_wr_data = d;
    endtask

    task automatic a_set_rd(input logic [3:0] ad, input logic [15:0] e);
        a_rd_en = 1'b1; a_rd_addr = ad;
        q_a.push_back('{e, cyc + 1});
    endtask

    task automatic a_idle();
        a_wr_en = 1'b0; a_rd_en = 1'b0; a_wr_lane_en = 2'b00;
    endtask

    task automatic b_set_wr(input logic [3:0] ad, input logic [1:0] ln, input logic [15:0] d);
        b_wr_en = 1'b1; b_wr_addr = ad; b_wr_lane_en = ln; b_wr_data = d;
    endtask

    task automatic b_set_rd(input logic [3:0] ad, input logic [15:0] e);
        b_rd_en = 1'b1; b_rd_addr = ad;
        q_b.push_back('{e, cyc + 2});
    endtask

    task automatic b_idle();
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_wr_lane_en = 2'b00;
    endtask

    // Monitor for instance A: compare each rd_valid beat against the queue head.
    always @(negedge clk) begin
        exp_t e;
        if (a_rd_valid) begin
            if (q_a.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL a_unexpected_valid: got rd_valid=1 data %h expected no read (cycle %0d)", a_rd_data, cyc);
            end else begin
                e = q_a.pop_front();
                check("a_rd_data", {16'h0, a_rd_data}, {16'h0, e.data});
                check("a_rd_cycle", cyc, e.due);
            end
        end else if (q_a.size() > 0 && q_a[0].due <= cyc) begin
            check("a_rd_valid_due", {31'h0, a_rd_valid}, 32'd1);
            void'(q_a.pop_front());
        end
    end

    // Monitor for instance B (two-cycle latency).
    always @(negedge clk) begin
        exp_t e;
        if (b_rd_valid) begin
            if (q_b.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL b_unexpected_valid: got rd_valid=1 data %h expected no read (cycle %0d)", b_rd_data, cyc);
            end else begin
                e = q_b.pop_front();
                check("b_rd_data", {16'h0, b_rd_data}, {16'h0, e.data});
                check("b_rd_cycle", cyc, e.due);
            end
        end else if (q_b.size() > 0 && q_b[0].due <= cyc) begin
            check("b_rd_valid_due", {31'h0, b_rd_valid}, 32'd1);
            void'(q_b.pop_front());
        end
    end

    initial begin
        int n;
        a_rst = 1'b1; a_clr = 1'b0; a_wr_addr = 4'd0; a_rd_addr = 4'd0; a_wr_data = 16'h0;
        b_rst = 1'b1; b_clr = 1'b0; b_wr_addr = 4'd0; b_rd_addr = 4'd0; b_wr_data = 16'h0;
        a_idle();
        b_idle();
        step(); step(); step();

        // reset values
        check("a_busy_in_rst", {31'h0, a_busy}, 32'd1);
        check("a_rd_data_rst", {16'h0, a_rd_data}, 32'h0);
        check("a_rd_valid_rst", {31'h0, a_rd_valid}, 32'd0);
        check("b_busy_in_rst", {31'h0, b_busy}, 32'd0);
        check("b_rd_data_rst", {16'h0, b_rd_data}, 32'h0);
        check("b_rd_valid_rst", {31'h0, b_rd_valid}, 32'd0);

        // A: automatic sweep after reset lasts exactly 16 cycles
        a_rst = 1'b0;
        b_rst = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin n++; step(); end
        check("a_reset_sweep_len", n, 32'd16);

        // A: every word is zero, back-to-back reads
        for (int i = 0; i < 16; i++) begin
            a_set_rd(4'(i), 16'h0000);
            step();
        end
        a_idle();
        step();

        // A: lane write merge and empty lane mask
        a_set_wr(4'd5, 2'b11, 16'hABCD); step();
        a_set_wr(4'd5, 2'b01, 16'h1234); step();
        a_set_wr(4'd5, 2'b00, 16'hFFFF); step();
        a_idle();
        a_set_rd(4'd5, 16'hAB34); step();
        a_idle();

        // A: same-cycle forwarding, write-first per lane
        a_set_wr(4'd3, 2'b11, 16'h1122); step();
        a_set_wr(4'd3, 2'b10, 16'h5566);
        a_set_rd(4'd3, 16'h5522); step();
        a_idle();
        a_set_rd(4'd3, 16'h5522); step();
        a_idle();
        step(); step(); step();
        check("a_rd_data_hold", {16'h0, a_rd_data}, 32'h5522);

        // A: clr with read -> pre-clear data; simultaneous write dropped
        a_clr = 1'b1;
        a_set_rd(4'd5, 16'hAB34);
        a_set_wr(4'd6, 2'b11, 16'hBEEF);
        step();
        a_clr = 1'b0;
        a_idle();
        n = 0;
        while (a_busy && n < 100) begin n++; step(); end
        check("a_clr_sweep_len", n, 32'd16);
        a_set_rd(4'd6, 16'h0000); step();
        a_set_rd(4'd5, 16'h0000); step();
        a_idle();
        step(); step();

        // B: fill memory with known pattern
        for (int i = 0; i < 16; i++) begin
            b_set_wr(4'(i), 2'b11, 16'hA000 + 16'(i));
            step();
        end
        b_idle();

        // B: pipelined back-to-back reads; write to addr 1 after its read
        b_set_rd(4'd0, 16'hA000); step();
        b_set_rd(4'd1, 16'hA001); step();
        b_set_rd(4'd2, 16'hA002);
        b_set_wr(4'd1, 2'b11, 16'hFFFF); step();
        b_idle();
        step(); step(); step(); step();
        b_set_rd(4'd1, 16'hFFFF); step();
        b_idle();

        // B: forwarding with latency 2
        b_set_wr(4'd3, 2'b11, 16'h1122); step();
        b_set_wr(4'd3, 2'b10, 16'h5566);
        b_set_rd(4'd3, 16'h5522); step();
        b_idle();
        step(); step(); step();

        // B: rst aborts the sweep after words 0..4 are cleared
        b_clr = 1'b1; step();
        b_clr = 1'b0;
        check("b_busy_after_clr", {31'h0, b_busy}, 32'd1);
        step(); step(); step(); step(); step();
        b_rst = 1'b1; step();
        check("b_busy_after_abort", {31'h0, b_busy}, 32'd0);
        b_rst = 1'b0; step();
        for (int i = 0; i < 16; i++) begin
            b_set_rd(4'(i), (i < 5) ? 16'h00FF : 16'hA000 + 16'(i));
            step();
        end
        b_idle();
        step(); step(); step(); step();

        // B: restarted sweep lasts 6 + 16 cycles; user ports ignored while busy
        b_clr = 1'b1; step();
        b_clr = 1'b0;
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_lane_en = 2'b11; b_wr_data = 16'h0BAD;
        b_rd_en = 1'b1; b_rd_addr = 4'd7;
        n = 0;
        while (b_busy && n < 100) begin
            n++;
            b_clr = (n == 6);
            step();
        end
        b_clr = 1'b0;
        b_idle();
        check("b_double_sweep_len", n, 32'd22);
        for (int i = 0; i < 16; i++) begin
            b_set_rd(4'(i), 16'h00FF);
            step();
        end
        b_idle();
        step(); step(); step(); step();

        check("a_queue_drained", q_a.size(), 32'd0);
        check("b_queue_drained", q_b.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
